// File: rtl/bcnn_pkg.sv
// Shared constants and sizing helpers for the BCNN pipeline stages.
package bcnn_pkg;

  localparam int unsigned MODE_OR  = 0;
  localparam int unsigned MODE_MAJ = 1;

  // Bits needed to hold values 0..v (at least 1).
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k);
    return in_dim / k;
  endfunction

  // Per-channel accumulator width: 1 bit for OR, ones-count for majority.
  function automatic int unsigned acc_width(input int unsigned mode, input int unsigned k);
    return (mode == MODE_MAJ) ? $clog2(k * k + 1) : 1;
  endfunction

endpackage

// File: rtl/pool_line_acc.sv
// One-row line buffer of partial window results; merged output is write-first
// (first row of a window group overwrites, later rows accumulate).
module pool_line_acc
  import bcnn_pkg::*;
#(
  parameter int unsigned DEPTH    = 13,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned CW       = 1,
  parameter int unsigned MODE     = 0,
  parameter int unsigned AW       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         first,
  input  logic [AW-1:0]                addr,
  input  logic [CHANNELS-1:0][CW-1:0]  din,
  output logic [CHANNELS-1:0][CW-1:0]  merged
);

  localparam int unsigned IW = cnt_width(DEPTH - 1);

  logic [CHANNELS-1:0][CW-1:0] mem [DEPTH];
  logic [CHANNELS-1:0][CW-1:0] rd;
  logic [IW-1:0]               idx;

  assign idx = IW'(addr);

  always_comb begin
    rd     = '0;
    merged = '0;
    if (addr < AW'(DEPTH)) rd = mem[idx];
    for (int c = 0; c < CHANNELS; c++) begin
      if (first)                  merged[c] = din[c];
      else if (MODE == MODE_MAJ)  merged[c] = rd[c] + din[c];
      else                        merged[c] = rd[c] | din[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[idx] <= merged;
    end
  end

endmodule

// File: rtl/bcnn_maxpool_kxk_mc.sv
// Streaming KxK stride-K multi-channel binary pool (OR or majority) with
// valid/ready on both sides and a single output register.
module bcnn_maxpool_kxk_mc
  import bcnn_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 26,
  parameter int unsigned IN_HEIGHT  = 26,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned POOL_K     = 2,
  parameter int unsigned MODE       = 0,
  parameter int unsigned MAJ_THRESH = (POOL_K * POOL_K + 1) / 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [CHANNELS-1:0] pixel_in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [CHANNELS-1:0] pixel_out,
  output logic                last_out,
  output logic                frame_done
);

  localparam int unsigned OUT_W = out_dim(IN_WIDTH, POOL_K);
  localparam int unsigned OUT_H = out_dim(IN_HEIGHT, POOL_K);
  localparam int unsigned CW    = acc_width(MODE, POOL_K);
  localparam int unsigned COLW  = cnt_width(IN_WIDTH - 1);
  localparam int unsigned ROWW  = cnt_width(IN_HEIGHT - 1);
  localparam int unsigned KW    = cnt_width(POOL_K - 1);
  localparam int unsigned OCW   = cnt_width(OUT_W);
  localparam int unsigned ORW   = cnt_width(OUT_H);

  logic [COLW-1:0] in_col;
  logic [ROWW-1:0] in_row;
  logic [KW-1:0]   kc, kr;
  // oc/orow saturate at OUT_W/OUT_H to mark trailing pixels outside any window.
  logic [OCW-1:0]  oc;
  logic [ORW-1:0]  orow;

  logic accept, col_last, row_last, kc_last, kr_last, in_window, line_en, emit;
  logic [CHANNELS-1:0][CW-1:0] hacc, hsum, merged;
  logic [CHANNELS-1:0]         pooled;

  assign ready_in  = !valid_out || ready_out;
  assign accept    = valid_in && ready_in;
  assign col_last  = in_col == COLW'(IN_WIDTH - 1);
  assign row_last  = in_row == ROWW'(IN_HEIGHT - 1);
  assign kc_last   = kc == KW'(POOL_K - 1);
  assign kr_last   = kr == KW'(POOL_K - 1);
  assign in_window = (oc < OCW'(OUT_W)) && (orow < ORW'(OUT_H));
  assign line_en   = accept && in_window && kc_last;
  assign emit      = line_en && kr_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_col <= '0;
      in_row <= '0;
      kc     <= '0;
      kr     <= '0;
      oc     <= '0;
      orow   <= '0;
    end else if (accept) begin
      if (col_last) begin
        in_col <= '0;
        kc     <= '0;
        oc     <= '0;
        if (row_last) begin
          in_row <= '0;
          kr     <= '0;
          orow   <= '0;
        end else begin
          in_row <= in_row + ROWW'(1);
          kr     <= kr_last ? '0 : kr + KW'(1);
          if (kr_last && orow < ORW'(OUT_H)) orow <= orow + ORW'(1);
        end
      end else begin
        in_col <= in_col + COLW'(1);
        kc     <= kc_last ? '0 : kc + KW'(1);
        if (kc_last && oc < OCW'(OUT_W)) oc <= oc + OCW'(1);
      end
    end
  end

  always_comb begin
    hsum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (MODE == MODE_MAJ) hsum[c] = ((kc == '0) ? '0 : hacc[c]) + CW'(pixel_in[c]);
      else                  hsum[c] = ((kc == '0) ? '0 : hacc[c]) | CW'(pixel_in[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       hacc <= '0;
    else if (accept) hacc <= hsum;
  end

  pool_line_acc #(
    .DEPTH    (OUT_W),
    .CHANNELS (CHANNELS),
    .CW       (CW),
    .MODE     (MODE),
    .AW       (OCW)
  ) u_line (
    .clk    (clk),
    .reset  (reset),
    .en     (line_en),
    .first  (kr == '0),
    .addr   (oc),
    .din    (hsum),
    .merged (merged)
  );

  always_comb begin
    pooled = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (MODE == MODE_MAJ) pooled[c] = merged[c] >= CW'(MAJ_THRESH);
      else                  pooled[c] = merged[c][0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out  <= 1'b0;
      pixel_out  <= '0;
      last_out   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (emit) begin
        valid_out <= 1'b1;
        pixel_out <= pooled;
        last_out  <= (oc == OCW'(OUT_W - 1)) && (orow == ORW'(OUT_H - 1));
      end else if (ready_out) begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcnn_maxpool_kxk_mc.sv
// Directed bench: 26x26 OR pool (a), 5x5 with trailing row/col (b), 2x2 4-channel majority (c).
module tb_bcnn_maxpool_kxk_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic reset;
  logic valid_in_a, ready_in_a, valid_out_a, last_out_a, frame_done_a;
  logic ready_out_a = 1'b1;
  logic [0:0] pixel_in_a, pixel_out_a;
  logic valid_in_b, ready_in_b, valid_out_b, last_out_b, frame_done_b;
  logic ready_out_b = 1'b1;
  logic [0:0] pixel_in_b, pixel_out_b;
  logic valid_in_c, ready_in_c, valid_out_c, last_out_c, frame_done_c;
  logic ready_out_c = 1'b1;
  logic [3:0] pixel_in_c, pixel_out_c;

  bcnn_maxpool_kxk_mc #(.IN_WIDTH(26), .IN_HEIGHT(26), .CHANNELS(1), .POOL_K(2), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in_a), .ready_in(ready_in_a),
    .pixel_in(pixel_in_a), .valid_out(valid_out_a), .ready_out(ready_out_a),
    .pixel_out(pixel_out_a), .last_out(last_out_a), .frame_done(frame_done_a));

  bcnn_maxpool_kxk_mc #(.IN_WIDTH(5), .IN_HEIGHT(5), .CHANNELS(1), .POOL_K(2), .MODE(0)) dut_b (
    .clk(clk), .reset(reset), .valid_in(valid_in_b), .ready_in(ready_in_b),
    .pixel_in(pixel_in_b), .valid_out(valid_out_b), .ready_out(ready_out_b),
    .pixel_out(pixel_out_b), .last_out(last_out_b), .frame_done(frame_done_b));

  bcnn_maxpool_kxk_mc #(.IN_WIDTH(2), .IN_HEIGHT(2), .CHANNELS(4), .POOL_K(2), .MODE(1),
                        .MAJ_THRESH(2)) dut_c (
    .clk(clk), .reset(reset), .valid_in(valid_in_c), .ready_in(ready_in_c),
    .pixel_in(pixel_in_c), .valid_out(valid_out_c), .ready_out(ready_out_c),
    .pixel_out(pixel_out_c), .last_out(last_out_c), .frame_done(frame_done_c));

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [4:0] q_c[$];
  int fd_a = 0, fd_b = 0;
  int stall_left = 0;
  bit stall_en = 0;
  logic img [26][26];
  logic gold [169];
  int ones, bad_last, bad;
  logic [3:0] vec_c [12];
  logic [3:0] exp_c [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs sampled on the falling edge; handshakes complete on the next rising edge.
  always @(negedge clk) begin
    if (stall_en && valid_out_a && !ready_out_a) begin
      chk("stall_ready_in", ready_in_a, 0);
      if (q_a.size() < 169) chk("stall_pixel_hold", pixel_out_a, gold[q_a.size()]);
    end
    if (valid_out_a && ready_out_a) begin
      q_a.push_back({last_out_a, pixel_out_a});
      if (stall_en && (q_a.size() % 10 == 0)) stall_left = 3;
    end
    if (frame_done_a) fd_a++;
    if (valid_out_b && ready_out_b) q_b.push_back({last_out_b, pixel_out_b});
    if (frame_done_b) fd_b++;
    if (valid_out_c && ready_out_c) q_c.push_back({last_out_c, pixel_out_c});
  end

  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      ready_out_a = 1'b0;
      stall_left--;
    end else begin
      ready_out_a = 1'b1;
    end
  end

  task automatic send(input int d, input logic [3:0] p);
    int n = 0;
    logic rdy;
    case (d)
      0:       begin valid_in_a = 1'b1; pixel_in_a = p[0]; end
      1:       begin valid_in_b = 1'b1; pixel_in_b = p[0]; end
      default: begin valid_in_c = 1'b1; pixel_in_c = p; end
    endcase
    forever begin
      @(negedge clk);
      rdy = (d == 0) ? ready_in_a : (d == 1) ? ready_in_b : ready_in_c;
      if (rdy || n >= 200) break;
      n++;
    end
    if (!rdy) chk("accept_timeout", rdy, 1);
    @(posedge clk);
    #1;
    valid_in_a = 1'b0;
    valid_in_b = 1'b0;
    valid_in_c = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_a_frame(input string tag, input int exp_ones);
    ones = 0;
    bad_last = 0;
    foreach (q_a[i]) begin
      if (q_a[i][0] === 1'b1) ones++;
      if (q_a[i][1] !== (i == 168)) bad_last++;
    end
    chk({tag, "_count"}, q_a.size(), 169);
    chk({tag, "_ones"}, ones, exp_ones);
    chk({tag, "_last"}, bad_last, 0);
    chk({tag, "_frame_done"}, fd_a, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    valid_in_a = 0; valid_in_b = 0; valid_in_c = 0;
    pixel_in_a = 0; pixel_in_b = 0; pixel_in_c = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", valid_out_a, 0);
    chk("rst_ready_in", ready_in_a, 1);
    chk("rst_pixel_out", pixel_out_a, 0);
    chk("rst_last_out", last_out_a, 0);
    chk("rst_frame_done", frame_done_a, 0);
    chk("rst_c_pixel_out", pixel_out_c, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // all-ones frame
    for (int i = 0; i < 676; i++) send(0, 4'h1);
    drain(5);
    check_a_frame("t1", 169);

    // single one at (5,7) lands in pooled (2,3) = index 29
    q_a.delete(); fd_a = 0;
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) send(0, {3'b0, (r == 5 && c == 7)});
    drain(5);
    check_a_frame("t2", 1);
    chk("t2_pos29", q_a[29][0], 1);

    // 5x5: ones only in trailing row/col
    for (int i = 0; i < 25; i++) begin
      send(1, {3'b0, (i / 5 == 4) || (i % 5 == 4)});
      if (i == 23) chk("t3_fd_before_last", frame_done_b, 0);
      if (i == 24) chk("t3_fd_after_last", frame_done_b, 1);
    end
    drain(5);
    chk("t3_count", q_b.size(), 4);
    chk("t3_out0", q_b[0], 2'b00);
    chk("t3_out1", q_b[1], 2'b00);
    chk("t3_out2", q_b[2], 2'b00);
    chk("t3_out3", q_b[3], 2'b10);
    chk("t3_frame_done", fd_b, 1);

    // random frame with periodic downstream stalls
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) img[r][c] = 1'($urandom_range(0, 1));
    for (int oy = 0; oy < 13; oy++)
      for (int ox = 0; ox < 13; ox++)
        gold[oy * 13 + ox] = img[2*oy][2*ox] | img[2*oy][2*ox+1] |
                             img[2*oy+1][2*ox] | img[2*oy+1][2*ox+1];
    q_a.delete(); fd_a = 0;
    stall_en = 1;
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) send(0, {3'b0, img[r][c]});
    drain(20);
    stall_en = 0;
    bad = 0;
    bad_last = 0;
    foreach (q_a[i]) begin
      if (i < 169 && q_a[i][0] !== gold[i]) bad++;
      if (q_a[i][1] !== (i == 168)) bad_last++;
    end
    chk("t4_count", q_a.size(), 169);
    chk("t4_golden_mismatches", bad, 0);
    chk("t4_last", bad_last, 0);
    chk("t4_frame_done", fd_a, 1);

    // 4-channel majority, threshold 2
    vec_c = '{4'b0101, 4'b0111, 4'b0100, 4'b0100,
              4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0011, 4'b0011, 4'b1100, 4'b1100};
    exp_c = '{4'b0101, 4'b0000, 4'b1111};
    for (int i = 0; i < 12; i++) send(2, vec_c[i]);
    drain(4);
    chk("t5_count", q_c.size(), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("t5_frame%0d", k), q_c[k], {1'b1, exp_c[k]});

    // reset mid-frame, then a clean all-ones frame
    q_a.delete(); fd_a = 0;
    for (int i = 0; i < 100; i++) send(0, 4'h1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", valid_out_a, 0);
    chk("t6_ready_after_rst", ready_in_a, 1);
    q_a.delete(); fd_a = 0;
    for (int i = 0; i < 676; i++) send(0, 4'h1);
    drain(5);
    check_a_frame("t6", 169);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
